// File: rtl/router_reg_if.sv
// Byte-side bus of the router register block: input port, FSM state strobes and FIFO data/status.
// The master side is the input port plus FSM. The slave side is router_reg.
interface router_reg_if #(
  parameter int DATA_W = 8
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_add;
  logic              ld_state;
  logic              lfd_state;
  logic              laf_state;
  logic              full_state;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [DATA_W-1:0] dout;
  logic              err;

  modport master (
    output pkt_valid, data_in, fifo_full, rst_int_reg,
           detect_add, ld_state, lfd_state, laf_state, full_state,
    input  parity_done, low_pkt_valid, dout, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_int_reg,
           detect_add, ld_state, lfd_state, laf_state, full_state,
    output parity_done, low_pkt_valid, dout, err
  );
endinterface

// File: rtl/router_reg.sv
// Datapath registers of the 1x3 router: header/payload/parity capture, FIFO byte mux, XOR parity check.
// Define ROUTER_REG_ERR_STICKY_EN to make err sticky until reset (detect_add no longer clears it).
module router_reg #(
  parameter int DATA_W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  router_reg_if.slave  bus
);

  logic [DATA_W-1:0] header_reg;
  logic [DATA_W-1:0] full_byte_reg;
  logic [DATA_W-1:0] int_parity;
  logic [DATA_W-1:0] pkt_parity;

  // Address 2'b11 is not a valid port, so such a header is never latched.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      header_reg <= '0;
    else if (bus.detect_add && bus.pkt_valid && bus.data_in[1:0] != 2'b11)
      header_reg <= bus.data_in;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      full_byte_reg <= '0;
    else if (bus.ld_state && bus.fifo_full)
      full_byte_reg <= bus.data_in;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      bus.dout <= '0;
    else if (bus.lfd_state)
      bus.dout <= header_reg;
    else if (bus.ld_state && !bus.fifo_full)
      bus.dout <= bus.data_in;
    else if (bus.laf_state)
      bus.dout <= full_byte_reg;
  end

  // full_state stalls accumulation so a byte parked in full_byte_reg is folded exactly once.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      int_parity <= '0;
    else if (bus.detect_add)
      int_parity <= '0;
    else if (bus.lfd_state)
      int_parity <= int_parity ^ header_reg;
    else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
      int_parity <= int_parity ^ bus.data_in;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      pkt_parity <= '0;
    else if (bus.ld_state && !bus.pkt_valid)
      pkt_parity <= bus.data_in;
  end

  // Parity byte accepted directly, or drained from full_byte_reg after a full stall.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      bus.parity_done <= 1'b0;
    else if (bus.detect_add)
      bus.parity_done <= 1'b0;
    else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
             (bus.laf_state && bus.low_pkt_valid && !bus.parity_done))
      bus.parity_done <= 1'b1;
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      bus.low_pkt_valid <= 1'b0;
    else if (bus.rst_int_reg)
      bus.low_pkt_valid <= 1'b0;
    else if (bus.ld_state && !bus.pkt_valid)
      bus.low_pkt_valid <= 1'b1;
  end

`ifdef ROUTER_REG_ERR_STICKY_EN
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      bus.err <= 1'b0;
    else if (bus.parity_done && (int_parity != pkt_parity))
      bus.err <= 1'b1;
  end
`else
  // detect_add wins so a stale parity_done from the last packet cannot re-raise err.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn)
      bus.err <= 1'b0;
    else if (bus.detect_add)
      bus.err <= 1'b0;
    else if (bus.parity_done)
      bus.err <= (int_parity != pkt_parity);
  end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Randomized packet-level bench for router_reg: expected bytes and err come from packet contents.
module tb_router_reg;
  localparam int DATA_W = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_reg_if #(.DATA_W(DATA_W)) rif();
  router_reg #(.DATA_W(DATA_W)) dut (.clock(clock), .resetn(resetn), .bus(rif.slave));

  int total = 0;
  int bad   = 0;

  // Model state: last accepted header and expected err level.
  logic [7:0] hdr_cur;
  logic       err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rif.pkt_valid   = 1'b0;
    rif.fifo_full   = 1'b0;
    rif.rst_int_reg = 1'b0;
    rif.detect_add  = 1'b0;
    rif.ld_state    = 1'b0;
    rif.lfd_state   = 1'b0;
    rif.laf_state   = 1'b0;
    rif.full_state  = 1'b0;
    rif.data_in     = 8'($urandom);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'(rif.dout), 32'h0);
    chk({tag, "_err"}, 32'(rif.err), 32'h0);
    chk({tag, "_pdone"}, 32'(rif.parity_done), 32'h0);
    chk({tag, "_lowpv"}, 32'(rif.low_pkt_valid), 32'h0);
  endtask

  // Asynchronous reset asserted between edges, held across one edge.
  task automatic mid_reset(input string tag);
    #3;
    resetn = 1'b1;
    #1;
    chk_zero({tag, "_async"});
    step();
    chk_zero({tag, "_hold"});
    resetn = 1'b0;
    hdr_cur = 8'h00;
    err_m   = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] hdr);
    idle(); rif.detect_add = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = hdr;
    step();
    if (hdr[1:0] != 2'b11) hdr_cur = hdr;
`ifndef ROUTER_REG_ERR_STICKY_EN
    err_m = 1'b0;
`endif
    chk("da_err", 32'(rif.err), 32'(err_m));
    chk("da_pdone", 32'(rif.parity_done), 32'h0);
    idle(); rif.lfd_state = 1'b1; rif.pkt_valid = 1'b1;
    step();
    chk("lfd_hdr", 32'(rif.dout), 32'(hdr_cur));
  endtask

  // full_idx selects which byte meets a full FIFO (len = the parity byte, -1 = none).
  task automatic send_pkt(input logic [7:0] hdr, input int len, input bit bad_par,
                          input int full_idx, input logic [7:0] full_val);
    logic [7:0] pl[$];
    logic [7:0] x, par, b, prev;
    bit         last;
    start_pkt(hdr);
    x = hdr_cur;
    for (int i = 0; i < len; i++) begin
      b = (i == full_idx) ? full_val : 8'($urandom);
      pl.push_back(b);
      x ^= b;
    end
    par  = bad_par ? ~x : x;
    prev = hdr_cur;
    for (int i = 0; i <= len; i++) begin
      last = (i == len);
      b = last ? par : pl[i];
      idle(); rif.ld_state = 1'b1; rif.pkt_valid = ~last; rif.data_in = b;
      rif.fifo_full = (i == full_idx);
      step();
      if (i != full_idx) begin
        chk("ld_dout", 32'(rif.dout), 32'(b));
      end else begin
        chk("full_hold", 32'(rif.dout), 32'(prev));
        idle(); rif.full_state = 1'b1; rif.fifo_full = 1'b1;
        step();
        chk("fs_hold", 32'(rif.dout), 32'(prev));
        idle(); rif.laf_state = 1'b1;
        step();
        chk("laf_dout", 32'(rif.dout), 32'(b));
      end
      prev = b;
    end
    chk("pdone", 32'(rif.parity_done), 32'h1);
    chk("lowpv", 32'(rif.low_pkt_valid), 32'h1);
    chk("err_pre", 32'(rif.err), 32'(err_m));
    idle();
    step();
`ifdef ROUTER_REG_ERR_STICKY_EN
    err_m = err_m | bad_par;
`else
    err_m = bad_par;
`endif
    chk("err", 32'(rif.err), 32'(err_m));
    idle(); rif.rst_int_reg = 1'b1;
    step();
    chk("rst_int", 32'(rif.low_pkt_valid), 32'h0);
    chk("pdone_keep", 32'(rif.parity_done), 32'h1);
    idle();
  endtask

  initial begin
    int len, fi;
    logic [7:0] hdr;
    hdr_cur = 8'h00;
    err_m   = 1'b0;
    idle();
    resetn = 1'b1;
    step(); step();
    chk_zero("por");
    resetn = 1'b0;
    step();

    send_pkt(8'h0E, 3, 1'b0, -1, 8'h00);
    send_pkt(8'h0E, 3, 1'b1, -1, 8'h00);
    mid_reset("rst_after_bad");
    send_pkt(8'h0E, 3, 1'b0, 1, 8'hA5);
    send_pkt(8'h0E, 3, 1'b1, 3, 8'h00);
    // Invalid address: previous header 0x0E must come out again.
    send_pkt(8'h0F, 3, 1'b0, -1, 8'h00);
    send_pkt(8'h09, 2, 1'b1, -1, 8'h00);
    send_pkt(8'h07, 1, 1'b0, -1, 8'h00);

    // Reset mid-payload, then an invalid header exposes the cleared header_reg.
    start_pkt(8'h16);
    idle(); rif.ld_state = 1'b1; rif.pkt_valid = 1'b1; rif.data_in = 8'h3C;
    step();
    chk("pre_rst_dout", 32'(rif.dout), 32'h3C);
    mid_reset("rst_mid");
    send_pkt(8'h0B, 2, 1'b0, -1, 8'h00);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 6);
      hdr = {6'(len), 2'($urandom_range(0, 3))};
      fi  = $urandom_range(0, len + 2);
      if (fi > len) fi = -1;
      send_pkt(hdr, len, 1'($urandom_range(0, 1)), fi, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
